// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: state encoding, default sizing and counter-width helper
// shared by the SRAM controller and its phase counter.
package sram_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int DEF_WAIT_CYCLES = 2;
   localparam int DEF_SRAM_ADDR_W = 17;
   localparam int DEF_SRAM_DATA_W = 16;

   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/sram_controller_phase_counter.sv
// sram_phase_counter: counts the cycles of one half-word phase and flags the
// final cycle; wraps to zero by itself so the next phase also starts at zero.
module sram_phase_counter
   import sram_controller_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_tc
);

   localparam int CW = cnt_width(WAIT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

   logic [CW-1:0] r_cnt;

   assign o_tc = (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clr || o_tc)
         r_cnt <= '0;
      else if (i_inc)
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/sram_controller.sv
// sram_controller: sequences one 32-bit load/store as two 16-bit accesses on an
// asynchronous SRAM, holding ready low until the word access completes.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
   parameter int SRAM_DATA_W = DEF_SRAM_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [31:0]            address,
   input  logic [31:0]            st_val,
   output logic                   ready,
   output logic [31:0]            read_data,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic                   sram_we_n,
   output logic [SRAM_DATA_W-1:0] sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [SRAM_DATA_W-1:0] sram_dq_in
);

   localparam int WW = SRAM_ADDR_W - 1;

   state_t                 r_state, w_next;
   logic                   r_wr;
   logic [WW-1:0]          r_word;
   logic [31:0]            r_st;
   logic [SRAM_DATA_W-1:0] r_lo, r_hi;
   logic                   w_req, w_phase, w_tc, w_unused;

   assign w_req     = mem_read | mem_write;
   assign w_phase   = (r_state == ST_LOW) || (r_state == ST_HIGH);
   assign read_data = {r_hi, r_lo};
   assign w_unused  = ^{address[31:SRAM_ADDR_W+1], address[1:0]};

   sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
      .clk   (clk),
      .rst_n (rst),
      .i_clr (!w_phase),
      .i_inc (w_phase),
      .o_tc  (w_tc)
   );

   always_comb begin
      w_next      = r_state;
      ready       = 1'b0;
      sram_addr   = '0;
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_dq_out = '0;
      case (r_state)
         ST_IDLE: begin
            w_next = w_req ? ST_LOW : ST_IDLE;
            ready  = !w_req;
         end
         ST_LOW, ST_HIGH: begin
            w_next      = !w_tc ? r_state : (r_state == ST_LOW) ? ST_HIGH : ST_DONE;
            sram_addr   = {r_word, r_state == ST_HIGH};
            sram_dq_oe  = r_wr;
            // final phase cycle releases WE while data is still driven (hold)
            sram_we_n   = !(r_wr && !w_tc);
            sram_dq_out = !r_wr ? '0 : (r_state == ST_HIGH) ? r_st[31:16] : r_st[15:0];
         end
         default: begin
            w_next = ST_IDLE;
            ready  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_wr    <= 1'b0;
         r_word  <= '0;
         r_st    <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_req) begin
            r_wr   <= mem_write;
            r_word <= address[SRAM_ADDR_W:2];
            r_st   <= st_val;
         end
         if (w_phase && w_tc && !r_wr) begin
            if (r_state == ST_HIGH)
               r_hi <= sram_dq_in;
            else
               r_lo <= sram_dq_in;
         end
      end
   end

endmodule
